// File: rtl/fnn_pkg.sv
// Shared types for the neuron weight-fetch path.
//   fetch_state_t    : sequencer FSM states.
//   weight_beat_t    : one streamed weight {data, idx, last} at default widths.
//   DEFAULT_DATA_WIDTH / DEFAULT_NUM_WEIGHT : default sizing of a neuron.
package fnn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_NUM_WEIGHT = 30;
  localparam int DEFAULT_ADDR_WIDTH = $clog2(DEFAULT_NUM_WEIGHT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] data;
    logic [DEFAULT_ADDR_WIDTH-1:0] idx;
    logic                          last;
  } weight_beat_t;

endpackage

// File: rtl/w_skid_fifo.sv
// Two-entry FIFO that absorbs the memory read latency and downstream stalls.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   push       : write push_data this cycle
//   push_data  : beat to store
//   pop        : retire the head entry this cycle (only when occ != 0)
//   head       : oldest stored beat
//   occ        : number of stored beats, 0..2
// Push and pop in the same cycle leave occ unchanged; the pushed beat lands
// behind the one being popped.
module w_skid_fifo #(
  parameter type beat_t = logic [7:0]
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  beat_t      push_data,
  input  logic       pop,
  output beat_t      head,
  output logic [1:0] occ
);

  beat_t slot [2];
  logic  rd_ptr;
  logic  wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot[0] <= '0;
      slot[1] <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      occ     <= 2'd0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= push_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = slot[rd_ptr];

  // The producer's issue rule must never let a third beat arrive.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && occ == 2'd2));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && occ == 2'd0));

endmodule

// File: rtl/weight_fetch_seq.sv
// Read-side sequencer for a per-neuron weight memory.
// On start it reads addresses 0..NUM_WEIGHT-1 from a memory with a 1-cycle
// registered read port and streams each weight with its index downstream.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle request for a full weight set (ignored unless idle)
//   busy        : high while fetching/draining
//   done        : one-cycle pulse after the last beat is accepted
//   mem_ren     : memory read enable
//   mem_radd    : memory read address
//   mem_rdata   : memory read data, valid the cycle after mem_ren
//   m_valid / m_ready / m_data / m_idx / m_last : weight stream
//   fsm_state   : current sequencer state (fetch_state_t encoding)
// Stream handshake: a beat transfers on every rising edge where m_valid and
// m_ready are both high; while m_valid is high and m_ready low the payload
// (m_data, m_idx, m_last) holds stable, and m_valid never depends on m_ready.
module weight_fetch_seq
  import fnn_pkg::*;
#(
  parameter int NUM_WEIGHT = DEFAULT_NUM_WEIGHT,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(NUM_WEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_radd,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0] m_idx,
  output logic                  m_last,
  output logic [1:0]            fsm_state
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  last;
  } beat_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WEIGHT - 1);

  fetch_state_t          state;
  fetch_state_t          state_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] idx_q;     // address of the read now in flight
  logic                  inflight;  // a read was issued last cycle
  logic [1:0]            occ;
  logic                  pop;
  logic                  room;
  beat_t                 head;
  beat_t                 push_beat;

  assign pop = m_valid & m_ready;

  // A new read may issue only if, counting this cycle's pop, the buffered
  // plus in-flight beats stay below 2: occ + inflight - pop < 2.
  assign room = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    mem_ren  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = FETCH;
      end
      FETCH: begin
        busy    = 1'b1;
        mem_ren = room;
        if (room && addr_q == LAST_ADDR) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // The final beat is the only one left when it is popped.
        if (pop && head.last && occ == 2'd1) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      idx_q    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= mem_ren;
      if (mem_ren) idx_q <= addr_q;
      if (state == IDLE && start) begin
        addr_q <= '0;
      end else if (mem_ren && addr_q != LAST_ADDR) begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  assign push_beat = '{data: mem_rdata, idx: idx_q, last: (idx_q == LAST_ADDR)};

  w_skid_fifo #(.beat_t(beat_t)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (push_beat),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  assign mem_radd  = addr_q;
  assign m_valid   = (occ != 2'd0);
  assign m_data    = head.data;
  assign m_idx     = head.idx;
  assign m_last    = head.last;
  assign fsm_state = state;

endmodule
